// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared widths and FSM state type for the 8-way round-robin mux arbiter
package mux8_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin pick; in req[7:0], start[2:0] -> out valid, idx[2:0] (first set req bit at or after start, wrapping)
module rr_pick8 import mux8_arb_pkg::*; (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;
  assign rot = N_REQ'({req, req} >> start);
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
  end
  assign valid = |rot;
  assign idx = start + off;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: bounded-burst round-robin owner of an 8:1 mux select; in clk, rst, req[7:0] -> out gnt[7:0], sel[2:0], busy
module mux8_rr_arbiter import mux8_arb_pkg::*; #(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);
  localparam int CNT_W = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  arb_state_t state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d, ptr_q, ptr_d, sel_q, sel_d, start, idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic valid, burst_end;
  assign start = state_q == GRANT ? owner_q + SEL_W'(1) : ptr_q;
  rr_pick8 u_pick (.req(req), .start(start), .valid(valid), .idx(idx));
  assign burst_end = !req[owner_q] || cnt_q == CNT_W'(MAX_BURST - 1);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      state_d = valid ? GRANT : IDLE;
      owner_d = valid ? idx : owner_q;
      cnt_d = '0;
    end else if (!burst_end) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ptr_d = owner_q + SEL_W'(1);
      state_d = valid ? GRANT : IDLE;
      owner_d = valid ? idx : owner_q;
      cnt_d = '0;
    end
    gnt_d = state_d == GRANT ? N_REQ'(1) << owner_d : '0;
    sel_d = state_d == GRANT ? owner_d : sel_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
    end
  end
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign busy = |gnt_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: self-checking bench for mux8_rr_arbiter with directed scenarios and a randomized reference model
module tb_mux8_rr_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic busy;
  int checks = 0;
  int failures = 0;
  bit m_act;
  int m_owner, m_ptr, m_cnt, m_sel;
  mux8_rr_arbiter #(.MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .busy(busy));
  always #5 clk = ~clk;
  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) if (r[(from + k) % 8]) return (from + k) % 8;
    return -1;
  endfunction
  task automatic model_reset();
    m_act = 0;
    m_owner = 0;
    m_ptr = 0;
    m_cnt = 0;
    m_sel = 0;
  endtask
  task automatic model_step(input logic [7:0] r);
    int p;
    if (!m_act) begin
      p = pick(r, m_ptr);
      if (p >= 0) begin
        m_act = 1;
        m_owner = p;
        m_cnt = 0;
      end
    end else if (r[m_owner] && m_cnt < MB - 1) begin
      m_cnt++;
    end else begin
      m_ptr = (m_owner + 1) % 8;
      p = pick(r, m_ptr);
      if (p >= 0) begin
        m_owner = p;
        m_cnt = 0;
      end else m_act = 0;
    end
    if (m_act) m_sel = m_owner;
  endtask
  task automatic tick(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gnt !== 8'h00) begin failures++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
    checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    model_reset();
    tick(8'hFF);
    checks++; if (gnt !== 8'h01) begin failures++; $display("FAIL reset_first_gnt got=%h exp=01", gnt); end
    checks++; if (sel !== 3'd0 || busy !== 1'b1) begin failures++; $display("FAIL reset_first_sel got=%0d/%b exp=0/1", sel, busy); end
  endtask
  task automatic test_sole();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(8'h20);
      checks++;
      if (gnt !== 8'h20 || sel !== 3'd5 || busy !== 1'b1) begin
        failures++;
        $display("FAIL sole_cyc%0d got gnt=%h sel=%0d busy=%b exp gnt=20 sel=5 busy=1", i, gnt, sel, busy);
      end
    end
  endtask
  task automatic test_rotation();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 9 * MB; i++) begin
      tick(8'hFF);
      exp = 8'h01 << ((i / MB) % 8);
      checks++;
      if (gnt !== exp || sel !== 3'((i / MB) % 8)) begin
        failures++;
        $display("FAIL rotation_cyc%0d got gnt=%h sel=%0d exp gnt=%h", i, gnt, sel, exp);
      end
    end
  endtask
  task automatic test_early_release();
    do_reset();
    tick(8'h44);
    tick(8'h44);
    checks++; if (gnt !== 8'h04) begin failures++; $display("FAIL early_owner got=%h exp=04", gnt); end
    req = 8'h40;
    #1;
    checks++; if (gnt !== 8'h04) begin failures++; $display("FAIL early_drop_cycle got=%h exp=04", gnt); end
    tick(8'h40);
    checks++; if (gnt !== 8'h40 || sel !== 3'd6) begin failures++; $display("FAIL early_handover got gnt=%h sel=%0d exp gnt=40 sel=6", gnt, sel); end
  endtask
  task automatic test_wrap();
    do_reset();
    repeat (MB) tick(8'h80);
    checks++; if (gnt !== 8'h80) begin failures++; $display("FAIL wrap_owner7 got=%h exp=80", gnt); end
    tick(8'h88);
    checks++; if (gnt !== 8'h08 || sel !== 3'd3) begin failures++; $display("FAIL wrap_next got gnt=%h sel=%0d exp gnt=08 sel=3", gnt, sel); end
  endtask
  task automatic test_async_reset();
    do_reset();
    tick(8'h10);
    tick(8'h10);
    checks++; if (gnt !== 8'h10) begin failures++; $display("FAIL async_pre got=%h exp=10", gnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL async_clear got gnt=%h busy=%b exp 00/0", gnt, busy); end
    checks++; if (sel !== 3'd0) begin failures++; $display("FAIL async_sel got=%0d exp=0", sel); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(8'h10);
    checks++; if (gnt !== 8'h10 || sel !== 3'd4) begin failures++; $display("FAIL async_restart got gnt=%h sel=%0d exp gnt=10 sel=4", gnt, sel); end
  endtask
  task automatic test_random();
    logic [7:0] r = '0;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r[$urandom_range(0, 7)] = 1'b0;
        2: r = r;
        default: r[$urandom_range(0, 7)] = 1'b1;
      endcase
      tick(r);
      exp = m_act ? 8'h01 << m_owner : 8'h00;
      checks++;
      if (gnt !== exp || sel !== 3'(m_sel) || busy !== m_act) begin
        failures++;
        $display("FAIL random_cyc%0d req=%h got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b", i, r, gnt, sel, busy, exp, m_sel, m_act);
      end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_sole();
    test_rotation();
    test_early_release();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 8:1 selection datapath among eight requesters. It grants one requester at a time for a bounded burst and drives the 3-bit select (s2 MSB … s0 LSB) that steers the 8:1 mux onto the shared output. It sits directly in front of the mux instance and is the only block allowed to change the mux select.

## Interface
- MAX_BURST, default 4: maximum consecutive grant cycles per owner; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request per source; bit i corresponds to mux input i (a=0 … h=7). Held high while the source wants the datapath.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  encoded owner index {s2,s1,s0} for the 8:1 mux, registered.
- busy  output  1  high while any grant is active; equals |gnt.

## Operation
- States are IDLE and GRANT. Internal registers:
  - owner[2:0]: current owner.
  - ptr[2:0]: search start point.
  - cnt: burst counter, width ceil(log2(MAX_BURST)), minimum 1 bit.
- Pick function: the first set bit of req, searching ptr, ptr+1, …, wrapping mod 8. It yields a valid flag and an index.
- IDLE:
  - gnt=0, busy=0; sel holds its last value.
  - If any req bit is set at a clock edge: go to GRANT, owner=pick(req, ptr), cnt=0.
- GRANT:
  - gnt=1<<owner, sel=owner, busy=1.
  - A burst ends at an edge where req[owner]==0, or where cnt==MAX_BURST-1.
  - If the burst has not ended: cnt increments.
  - If the burst ends:
    - ptr=owner+1 (mod 8).
    - Re-pick in the same cycle from owner+1. The current owner is the last candidate.
    - If valid: stay in GRANT with the new owner and cnt=0. There is no bubble.
    - Otherwise go to IDLE.
- A sole requester whose burst is exhausted is re-granted immediately. gnt stays high and cnt restarts at 0.
- With MAX_BURST=1, arbitration happens every cycle.
- req bits that toggle without being granted are ignored. There is no latching of request pulses.
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state=IDLE, gnt=0, sel=0, busy=0, owner=0, ptr=0, cnt=0.
- Invariants:
  - gnt is always zero or one-hot.
  - While busy=1, sel equals the index of the set gnt bit.

## Timing
- Grant latency from IDLE: req sampled high at edge k gives gnt valid after edge k (1 cycle).
- Handover: the new owner's gnt is active in the cycle immediately after the old owner's last granted cycle.
- Release by drop: the owner sees gnt for exactly one cycle in which its own req is low. Requesters must tolerate this.
- Full burst: with req held continuously, the owner holds gnt for exactly MAX_BURST cycles before rotation if others request.
- sel and gnt change on the same edge. The mux output follows combinationally in the same cycle.
- Fairness: with all eight requesting, each owner waits at most 7·MAX_BURST cycles between grants.
- Asynchronous reset assertion clears outputs without a clock edge. Deassertion is synchronised by the user; the first arbitration occurs at the first edge after deassertion.

## Structure
- Package mux8_arb_pkg:
  - N_REQ=8 and SEL_W=3.
  - typedef enum {IDLE, GRANT} arb_state_t.
- Sub-module rr_pick8:
  - Purely combinational.
  - Inputs: req[7:0], start[2:0]. Outputs: valid, idx[2:0].
  - Instantiated once, with start=ptr in IDLE and start=owner+1 in GRANT.
- Top level: state register, owner/ptr/cnt registers, output registers. The target is 120–200 lines.

## Test plan
- Reset:
  - Hold rst=1 with req=8'hFF: gnt=0, sel=0, busy=0.
  - Release rst: after the first edge, gnt=8'h01, sel=0.
- Sole requester, MAX_BURST=4: req=8'h20 held 12 cycles → gnt=8'h20, sel=5, busy=1 continuously with no gap; cnt wraps every 4 cycles.
- Full rotation, MAX_BURST=4: req=8'hFF → owners 0,1,…,7,0, each for exactly 4 cycles, with no idle cycles.
- Early release with handover:
  - Owner 2 drops req after 2 granted cycles while req[6]=1.
  - gnt=8'h04 is seen for one cycle with req[2]=0, then gnt=8'h40, sel=6 on the next edge.
- Wrap-around: owner 7 ends its burst with req=8'h88 → next owner 3 (searched 0..7 starting from 0), sel=3.
- Async reset mid-burst:
  - Assert rst between edges while gnt=8'h10: gnt=0, busy=0 immediately, before the next clock edge.
  - After release with req=8'h10: arbitration restarts from ptr=0 and gnt=8'h10.
